// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue sequencer between the FP decoder and the FP
// execution units. It accepts one one-hot operation and drives the
// register-file read. It then pulses the unit start, waits the unit's fixed
// latency and raises the write-back strobe. Only one op is in flight at a time.
module fpu_issue_ctrl #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 16,
    parameter int LAT_SQRT = 20,
    parameter int LAT_CMP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [9:0] op_en,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       flush,
    output logic       rf_rd_en,
    output logic [4:0] rf_rs1,
    output logic [4:0] rf_rs2,
    output logic [9:0] unit_start,
    output logic [3:0] res_sel,
    output logic       wb_en,
    output logic [4:0] wb_rd,
    output logic       wb_int,
    output logic       busy,
    output logic       illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Countdown reload values: the counter holds LAT-1 in the first EXEC
    // cycle, so WB follows exactly LAT EXEC cycles.
    localparam logic [4:0] ADD_M1  = 5'(LAT_ADD - 1);
    localparam logic [4:0] MUL_M1  = 5'(LAT_MUL - 1);
    localparam logic [4:0] DIV_M1  = 5'(LAT_DIV - 1);
    localparam logic [4:0] SQRT_M1 = 5'(LAT_SQRT - 1);
    localparam logic [4:0] CMP_M1  = 5'(LAT_CMP - 1);

    state_t      state_reg;
    logic [9:0]  op_reg;
    logic [4:0]  rd_reg;
    logic [4:0]  cnt_reg;
    logic [4:0]  lat_m1;
    logic [3:0]  sel_idx;
    logic        legal;

    // Mask of unit positions whose binary index has bit b set.
    function automatic logic [9:0] idx_mask(input int b);
        logic [9:0] m;
        for (int i = 0; i < 10; i++) begin
            m[i] = (((i >> b) & 1) == 1);
        end
        return m;
    endfunction

    // One-hot to binary encoder for the result-mux select.
    for (genvar gi = 0; gi < 4; gi++) begin : g_idx
        assign sel_idx[gi] = |(op_en & idx_mask(gi));
    end

    // Exactly one unit bit may be set.
    assign legal = (op_en != 10'd0) && ((op_en & (op_en - 10'd1)) == 10'd0);

    assign op_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);

    // Latency selection from the latched unit; compare ops share LAT_CMP.
    always_comb begin
        lat_m1 = CMP_M1;
        if (op_reg[0] || op_reg[1]) begin
            lat_m1 = ADD_M1;
        end else if (op_reg[2]) begin
            lat_m1 = DIV_M1;
        end else if (op_reg[3]) begin
            lat_m1 = MUL_M1;
        end else if (op_reg[4]) begin
            lat_m1 = SQRT_M1;
        end
    end

    // Sequencer FSM with registered strobes; flush overrides every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            rd_reg     <= '0;
            cnt_reg    <= '0;
            rf_rd_en   <= 1'b0;
            rf_rs1     <= '0;
            rf_rs2     <= '0;
            unit_start <= '0;
            res_sel    <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_int     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            rf_rd_en   <= 1'b0;
            rf_rs1     <= '0;
            rf_rs2     <= '0;
            unit_start <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_int     <= 1'b0;
            illegal    <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
                res_sel   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (op_valid) begin
                            if (legal) begin
                                state_reg <= READ;
                                op_reg    <= op_en;
                                rd_reg    <= rd;
                                rf_rd_en  <= 1'b1;
                                rf_rs1    <= rs1;
                                rf_rs2    <= rs2;
                                res_sel   <= sel_idx;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        state_reg  <= EXEC;
                        cnt_reg    <= lat_m1;
                        unit_start <= op_reg;
                    end
                    EXEC: begin
                        if (cnt_reg == 5'd0) begin
                            state_reg <= WB;
                            wb_en     <= 1'b1;
                            wb_rd     <= rd_reg;
                            wb_int    <= |op_reg[9:7];
                        end else begin
                            cnt_reg <= cnt_reg - 5'd1;
                        end
                    end
                    WB: begin
                        state_reg <= IDLE;
                        res_sel   <= '0;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: directed scenarios with literal expectations
// plus a per-cycle check against a transaction-schedule model.
module tb_fpu_issue_ctrl;

    localparam int LAT_ADD  = 3;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = 16;
    localparam int LAT_SQRT = 20;
    localparam int LAT_CMP  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op_valid = 1'b0;
    logic [9:0] op_en = '0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic [4:0] rd = '0;
    logic       flush = 1'b0;
    logic       op_ready;
    logic       rf_rd_en;
    logic [4:0] rf_rs1;
    logic [4:0] rf_rs2;
    logic [9:0] unit_start;
    logic [3:0] res_sel;
    logic       wb_en;
    logic [4:0] wb_rd;
    logic       wb_int;
    logic       busy;
    logic       illegal;

    fpu_issue_ctrl #(
        .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
        .LAT_SQRT(LAT_SQRT), .LAT_CMP(LAT_CMP)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_en(op_en), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
        .rf_rd_en(rf_rd_en), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .unit_start(unit_start), .res_sel(res_sel), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_int(wb_int), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_act = 1'b0;
    int         m_t = -100;
    int         m_lat = 1;
    int         m_ill = -100;
    logic [9:0] m_op = '0;
    logic [4:0] m_rs1 = '0;
    logic [4:0] m_rs2 = '0;
    logic [4:0] m_rd = '0;

    function automatic int lat_of(input logic [9:0] op);
        if (op[0] || op[1]) return LAT_ADD;
        if (op[2]) return LAT_DIV;
        if (op[3]) return LAT_MUL;
        if (op[4]) return LAT_SQRT;
        return LAT_CMP;
    endfunction

    function automatic int idx_of(input logic [9:0] op);
        for (int i = 0; i < 10; i++) if (op[i]) return i;
        return 0;
    endfunction

    // Busy from the cycle after transfer through the write-back cycle.
    function automatic bit m_busy(input int c);
        return m_act && (c >= m_t + 1) && (c <= m_t + m_lat + 2);
    endfunction

    // Check every cycle against the schedule, then decide the next edge.
    always @(negedge clk) begin
        bit b;
        if (!rst) begin
            m_act = 1'b0;
            m_ill = -100;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_op_ready", 32'(op_ready), 32'd1);
            chk("rst_rf_rd_en", 32'(rf_rd_en), 32'd0);
            chk("rst_unit_start", 32'(unit_start), 32'd0);
            chk("rst_wb_en", 32'(wb_en), 32'd0);
            chk("rst_res_sel", 32'(res_sel), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
        end else begin
            b = m_busy(cyc);
            chk("busy", 32'(busy), 32'(b));
            chk("op_ready", 32'(op_ready), 32'(!b));
            chk("rf_rd_en", 32'(rf_rd_en), 32'(m_act && cyc == m_t + 1));
            if (m_act && cyc == m_t + 1) begin
                chk("rf_rs1", 32'(rf_rs1), 32'(m_rs1));
                chk("rf_rs2", 32'(rf_rs2), 32'(m_rs2));
            end
            chk("unit_start", 32'(unit_start), (m_act && cyc == m_t + 2) ? 32'(m_op) : 32'd0);
            chk("wb_en", 32'(wb_en), 32'(m_act && cyc == m_t + m_lat + 2));
            if (m_act && cyc == m_t + m_lat + 2) begin
                chk("wb_rd", 32'(wb_rd), 32'(m_rd));
                chk("wb_int", 32'(wb_int), 32'(m_op[7] || m_op[8] || m_op[9]));
            end
            if (b) chk("res_sel", 32'(res_sel), 32'(idx_of(m_op)));
            chk("illegal", 32'(illegal), 32'(cyc == m_ill));
            if (flush) begin
                m_act = 1'b0;
            end else if (!b && op_valid) begin
                if ($countones(op_en) == 1) begin
                    m_act = 1'b1;
                    m_t   = cyc;
                    m_op  = op_en;
                    m_rs1 = rs1;
                    m_rs2 = rs2;
                    m_rd  = rd;
                    m_lat = lat_of(op_en);
                end else begin
                    m_ill = cyc + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [9:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, output int t0);
        op_valid = 1'b1;
        op_en = op;
        rs1 = a;
        rs2 = b;
        rd = d;
        t0 = cyc;
        step();
        op_valid = 1'b0;
    endtask

    task automatic fadd_scenario();
        int t0;
        issue(10'b0000000001, 5'd3, 5'd4, 5'd5, t0);
        chk("s1_rd_en", 32'(rf_rd_en), 32'd1);
        chk("s1_rs1", 32'(rf_rs1), 32'd3);
        chk("s1_rs2", 32'(rf_rs2), 32'd4);
        step();
        chk("s1_start", 32'(unit_start), 32'h001);
        step();
        chk("s1_start_off", 32'(unit_start), 32'h000);
        step();
        step();
        chk("s1_wb_en", 32'(wb_en), 32'd1);
        chk("s1_wb_rd", 32'(wb_rd), 32'd5);
        chk("s1_wb_int", 32'(wb_int), 32'd0);
        chk("s1_res_sel", 32'(res_sel), 32'd0);
        step();
        chk("s1_ready", 32'(op_ready), 32'd1);
        chk("s1_cycles", 32'(cyc - t0), 32'd6);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int acc;
        repeat (3) step();
        chk("reset_ready", 32'(op_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step();

        // Scenario 1: FADD
        fadd_scenario();

        // Scenario 2: FDIV with a second op held valid
        issue(10'b0000000100, 5'd1, 5'd2, 5'd9, t0);
        op_valid = 1'b1;
        op_en = 10'b0000000001;
        rs1 = 5'd6;
        rs2 = 5'd7;
        rd = 5'd1;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            if (cyc == t0 + 18) begin
                chk("s2_wb_en", 32'(wb_en), 32'd1);
                chk("s2_wb_rd", 32'(wb_rd), 32'd9);
            end
            if (op_ready) begin
                acc = cyc;
                step();
                op_valid = 1'b0;
                break;
            end
            step();
        end
        chk("s2_accept_cycle", 32'(acc - t0), 32'd19);
        repeat (LAT_ADD + 3) step();

        // Scenario 3: FEQ
        issue(10'b0010000000, 5'd2, 5'd3, 5'd7, t0);
        step();
        chk("s3_start", 32'(unit_start), 32'h080);
        step();
        chk("s3_wb_en", 32'(wb_en), 32'd1);
        chk("s3_wb_int", 32'(wb_int), 32'd1);
        chk("s3_res_sel", 32'(res_sel), 32'd7);
        chk("s3_wb_rd", 32'(wb_rd), 32'd7);
        step();

        // Scenario 4: illegal op_en patterns
        issue(10'b0000000000, 5'd1, 5'd1, 5'd1, t0);
        chk("s4a_illegal", 32'(illegal), 32'd1);
        chk("s4a_ready", 32'(op_ready), 32'd1);
        chk("s4a_rd_en", 32'(rf_rd_en), 32'd0);
        step();
        chk("s4a_illegal_off", 32'(illegal), 32'd0);
        issue(10'b0000000101, 5'd1, 5'd1, 5'd1, t0);
        chk("s4b_illegal", 32'(illegal), 32'd1);
        chk("s4b_ready", 32'(op_ready), 32'd1);
        repeat (3) begin
            step();
            chk("s4b_no_start", 32'(unit_start), 32'd0);
            chk("s4b_no_wb", 32'(wb_en), 32'd0);
        end

        // Scenario 5: FMUL flushed in cycle 3
        issue(10'b0000001000, 5'd8, 5'd9, 5'd10, t0);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s5_ready", 32'(op_ready), 32'd1);
        chk("s5_busy", 32'(busy), 32'd0);
        while (cyc <= t0 + 10) begin
            chk("s5_no_wb", 32'(wb_en), 32'd0);
            step();
        end

        // Flush during READ and flush blocking acceptance in IDLE
        issue(10'b0000000100, 5'd4, 5'd5, 5'd6, t0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fr_no_start", 32'(unit_start), 32'd0);
        chk("fr_ready", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_en = 10'b0000000001;
        flush = 1'b1;
        step();
        op_valid = 1'b0;
        flush = 1'b0;
        chk("fi_not_accepted", 32'(busy), 32'd0);
        chk("fi_no_rd_en", 32'(rf_rd_en), 32'd0);
        step();

        // Every unit once, checked by the model
        for (int i = 0; i < 10; i++) begin
            issue(10'(1 << i), 5'(i), 5'(i + 1), 5'(i + 20), t0);
            repeat (lat_of(10'(1 << i)) + 2) step();
        end

        // Scenario 6: FSQRT interrupted by reset at cycle 8
        issue(10'b0000010000, 5'd11, 5'd12, 5'd13, t0);
        while (cyc < t0 + 8) step();
        rst = 1'b0;
        #1;
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_ready", 32'(op_ready), 32'd1);
        chk("s6_start", 32'(unit_start), 32'd0);
        chk("s6_wb_en", 32'(wb_en), 32'd0);
        chk("s6_res_sel", 32'(res_sel), 32'd0);
        chk("s6_rd_en", 32'(rf_rd_en), 32'd0);
        step();
        step();
        rst = 1'b1;
        fadd_scenario();
        repeat (25) begin
            step();
            chk("s6_no_stale_wb", 32'(wb_en), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Sequencer between the FP instruction decoder and the FP execution units. It accepts one decoded FP operation at a time through a valid/ready handshake and drives the register-file read. It then issues a one-cycle start pulse to the selected unit, waits that unit's fixed latency, and produces the write-back strobe and result-mux select. Only one operation is in flight at any time.

## Interface
Parameters:
- LAT_ADD, 3: cycles from start to result for FADD/FSUB (1..32)
- LAT_MUL, 4: cycles for FMUL (1..32)
- LAT_DIV, 16: cycles for FDIV (1..32)
- LAT_SQRT, 20: cycles for FSQRT (1..32)
- LAT_CMP, 1: cycles for FMAX/FMIN/FEQ/FLT/FLE (1..32)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all flops rise-edge
- rst  in  1  asynchronous reset, active-low
- op_valid  in  1  decoded operation present
- op_ready  out  1  controller can accept; equals (state==IDLE)
- op_en  in  10  one-hot unit select: [0]add [1]sub [2]div [3]mul [4]sqrt [5]max [6]min [7]eq [8]lt [9]le
- rs1, rs2, rd  in  5 each  register addresses
- flush  in  1  synchronous abort of any operation
- rf_rd_en  out  1  register-file read strobe
- rf_rs1, rf_rs2  out  5 each  read addresses
- unit_start  out  10  one-cycle start pulse, same bit order as op_en
- res_sel  out  4  binary index (0..9) of the active unit
- wb_en  out  1  write-back strobe
- wb_rd  out  5  write-back address
- wb_int  out  1  1 = result goes to integer file (eq/lt/le)
- busy  out  1  state != IDLE
- illegal  out  1  one-cycle pulse on a rejected op

## Operation
- States are IDLE, READ, EXEC and WB. Reset sets the state to IDLE.
- Reset values: all registered outputs are 0. op_ready reads 1 because the state is IDLE, but no transfer can occur while rst is low.
- Transfer occurs when op_valid & op_ready are both high on a rising edge. The controller then latches op_en, rs1, rs2 and rd.
- An op_en that is not one-hot (zero bits set, or two or more) is rejected:
  - illegal=1 for the next cycle;
  - the state stays IDLE;
  - there are no reads, starts or write-back.
- IDLE -> READ on a legal transfer.
- READ lasts one cycle:
  - rf_rd_en=1; rf_rs1/rf_rs2 carry the latched addresses;
  - res_sel is loaded and held until the FSM returns to IDLE;
  - the countdown counter is loaded with LAT-1 for the selected unit. add/sub use LAT_ADD; min/max/eq/lt/le use LAT_CMP.
  - Next state is EXEC.
- EXEC:
  - unit_start equals the latched op_en in the first EXEC cycle only; otherwise it is 0.
  - The counter decrements each cycle. When it is 0, the next state is WB.
- WB lasts one cycle:
  - wb_en=1 and wb_rd equals the latched rd;
  - wb_int=1 iff bit 7, 8 or 9 is set;
  - next state is IDLE.
- flush has priority over everything. From any state the next state is IDLE, and no further rf_rd_en, unit_start or wb_en is generated.
- flush high in IDLE blocks acceptance: a transfer requires flush=0.
- The 5-bit counter is wide enough for LAT up to 32. Wrap-around never occurs, because the counter only reloads from READ.
- op_valid asserted while busy is ignored. The requester holds it until op_ready is high.

## Timing
- Transfer at edge T gives:
  - READ in cycle T+1;
  - first EXEC cycle at T+2, which carries unit_start;
  - WB at cycle T+1+LAT+1 = T+LAT+2;
  - IDLE, with op_ready=1, at T+LAT+3.
- Throughput is one op per LAT+3 cycles. A back-to-back op is accepted on the first IDLE cycle.
- illegal pulses in cycle T+1 and op_ready stays 1 throughout.
- rst low at any time forces IDLE and zeroes all outputs asynchronously. An op in flight is discarded with no write-back.
- The first transfer is possible on the first rising edge after rst goes high.

## Test plan
- FADD (op_en=10'b0000000001), rs1=3, rs2=4, rd=5 accepted at cycle 0:
  - rf_rd_en=1 with rs1=3/rs2=4 at cycle 1;
  - unit_start=10'b1 at cycle 2 only;
  - wb_en=1, wb_rd=5, wb_int=0, res_sel=0 at cycle 5;
  - op_ready=1 at cycle 6.
- FDIV, rd=9, at cycle 0 with a second op held valid:
  - wb_en at cycle 18;
  - the second op is accepted at cycle 19, not earlier.
- FEQ (bit 7), rd=7:
  - unit_start at cycle 2;
  - wb_en=1, wb_int=1, res_sel=7 at cycle 3.
- op_en=10'b0 and op_en=10'b0000000101, each accepted at cycle 0:
  - illegal=1 at cycle 1;
  - no rf_rd_en, unit_start or wb_en;
  - op_ready stays 1.
- FMUL accepted at cycle 0, flush=1 during cycle 3:
  - IDLE and op_ready=1 at cycle 4;
  - wb_en stays 0 through cycle 10.
- FSQRT accepted at cycle 0, rst driven low at cycle 8:
  - all outputs 0 immediately;
  - after release, FADD behaves as in scenario 1 with no stale write-back.
